ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Carries decode-stage control bits from the `controller` through the ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves data and control hazards for the 5-stage RV32I core: forwarding selects, load-use stall and branch/jump flush. Sits directly downstream of `controller` and alongside the datapath pipeline registers, which it drives with stall/flush.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register-file address width
- `ALUCTRL_W`, 3, ALUControl width

Ports:
- `clk`  in  1  core clock, rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD`  in  1 each  decode control from `controller`
- `ResultSrcD`  in  2  00 ALU, 01 memory, 10 PC+4
- `ALUControlD`  in  ALUCTRL_W  ALU operation
- `Rs1D, Rs2D, RdD`  in  REG_ADDR_W each  decode register fields
- `ZeroE`  in  1  ALU zero flag, execute stage
- `ALUControlE`, `ALUSrcE`  out  execute control
- `PCSrcE`  out  1  (BranchE & ZeroE) | JumpE
- `MemWriteM, RegWriteM`  out  1 each; `RdM`  out  REG_ADDR_W
- `RegWriteW`  out  1; `ResultSrcW`  out  2; `RdW`  out  REG_ADDR_W
- `ForwardAE, ForwardBE`  out  2  00 register file, 10 ALUResultM, 01 ResultW
- `StallF, StallD, FlushD, FlushE`  out  1 each  to datapath PC and IF/ID/ID/EX registers

## Operation
- ID/EX register holds RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, Rs1, Rs2, Rd.
- EX/MEM holds RegWrite, ResultSrc, MemWrite, Rd. MEM/WB holds RegWrite, ResultSrc, Rd.
- All fields of all three registers reset to 0, forming a NOP bubble. Consequently every output resets to 0, except `PCSrcE`/`Forward*E`/`Stall*`/`Flush*`, which reset to 0 as combinational functions of zeroed state.
- Forwarding, evaluated for `ForwardAE` on Rs1E and likewise `ForwardBE` on Rs2E:
  - 10 if RegWriteM, RdM==Rs1E and Rs1E!=0.
  - Else 01 if RegWriteW, RdW==Rs1E and Rs1E!=0.
  - Else 00. MEM takes priority over WB.
- lwStall = (ResultSrcE==01) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D) & ~PCSrcE.
- StallF = StallD = lwStall. FlushD = PCSrcE. FlushE = lwStall | PCSrcE.
- FlushE loads the ID/EX register with all-zero control and addresses on the next edge. EX/MEM and MEM/WB are never stalled or flushed.
- A taken branch overrides a simultaneous load-use condition: no stall, and both D and E are flushed.
- Rd==x0 writes propagate with RegWrite set but never cause forwarding or stall.

## Timing
- Each register advances on the rising `clk` edge. Control appears in E one cycle after D, in M after two cycles, in W after three.
- Hazard outputs are combinational from current register state and D inputs, valid within the same cycle.
- A load followed by a dependent instruction costs exactly one bubble. On the following cycle ForwardxE=01 from WB.
- A taken branch or jump resolved in E squashes exactly two instructions (D and E).
- `reset_n` low at any time clears all registers immediately, without waiting for a clock edge. Operation resumes on the first rising edge after deassertion.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - ResultSrc encodings RES_ALU/RES_MEM/RES_PC4.
  - Forward encodings FWD_RF/FWD_W/FWD_M.
  - Packed structs `ctrl_e_t`, `ctrl_m_t`, `ctrl_w_t` for the stage bundles.
- One combinational sub-module `hazard_unit` computes forwarding, lwStall, stall and flush. The pipeline registers stay in `ctrl_pipe`.

## Test plan
- Reset mid-stream: drive RegWriteD=1, RdD=5 for 3 cycles, pulse reset_n low asynchronously -> all outputs 0 before the next edge.
- Back-to-back ALU: `add x5` then `sub` using Rs1D=5 -> next cycle ForwardAE=10. One instruction gap -> ForwardAE=01. Rs1=0 with RdM=0 -> ForwardAE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. Next cycle RegWriteE=0 bubble, then ForwardBE=01.
- Branch taken: BranchE=1, ZeroE=1 -> PCSrcE=1, FlushD=FlushE=1. Next cycle E control all 0. With ZeroE=0 -> no flush.
- Simultaneous: JumpE=1 and a load-use match present -> StallF=0, FlushD=FlushE=1.
- Latency: MemWriteD=1 at cycle n -> MemWriteM=1 at n+2. RegWriteD=1, RdD=9, ResultSrcD=10 -> RegWriteW=1, RdW=9, ResultSrcW=10 at n+3.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings and stage-bundle types for the control pipeline.
// Register addresses and ALUControl stay outside the structs so their widths follow module parameters.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
    } ctrl_e_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-control inputs and pipeline/hazard outputs of ctrl_pipe, bundled as one interface.
interface ctrl_pipe_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUCTRL_W  = 3
);
    logic                  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]            ResultSrcD;
    logic [ALUCTRL_W-1:0]  ALUControlD;
    logic [REG_ADDR_W-1:0] Rs1D, Rs2D, RdD;
    logic                  ZeroE;

    logic [ALUCTRL_W-1:0]  ALUControlE;
    logic                  ALUSrcE;
    logic                  PCSrcE;
    logic                  MemWriteM, RegWriteM;
    logic [REG_ADDR_W-1:0] RdM;
    logic                  RegWriteW;
    logic [1:0]            ResultSrcW;
    logic [REG_ADDR_W-1:0] RdW;
    logic [1:0]            ForwardAE, ForwardBE;
    logic                  StallF, StallD, FlushD, FlushE;

    modport slave (
        input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD,
               ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
        output ALUControlE, ALUSrcE, PCSrcE, MemWriteM, RegWriteM, RdM,
               RegWriteW, ResultSrcW, RdW, ForwardAE, ForwardBE,
               StallF, StallD, FlushD, FlushE
    );

    modport master (
        output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD,
               ALUControlD, Rs1D, Rs2D, RdD, ZeroE,
        input  ALUControlE, ALUSrcE, PCSrcE, MemWriteM, RegWriteM, RdM,
               RegWriteW, ResultSrcW, RdW, ForwardAE, ForwardBE,
               StallF, StallD, FlushD, FlushE
    );
endinterface

// File: rtl/ctrl_pipe_hazard_unit.sv
// Combinational hazard resolution: operand forwarding, load-use stall and branch/jump flush.
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [1:0]            result_src_e,
    input  logic                  pcsrc_e,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_w,
    input  logic [REG_ADDR_W-1:0] rd_w,
    output logic [1:0]            forward_ae,
    output logic [1:0]            forward_be,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e
);
    fwd_e fwd_a, fwd_b;
    logic lw_stall;

    // MEM result is younger than WB, so it wins when both match.
    always_comb begin
        fwd_a = FWD_RF;
        if (rs1_e != '0 && reg_write_m && rd_m == rs1_e)
            fwd_a = FWD_M;
        else if (rs1_e != '0 && reg_write_w && rd_w == rs1_e)
            fwd_a = FWD_W;

        fwd_b = FWD_RF;
        if (rs2_e != '0 && reg_write_m && rd_m == rs2_e)
            fwd_b = FWD_M;
        else if (rs2_e != '0 && reg_write_w && rd_w == rs2_e)
            fwd_b = FWD_W;
    end

    assign forward_ae = fwd_a;
    assign forward_be = fwd_b;

    // A taken branch squashes the dependent instruction anyway, so it cancels the stall.
    assign lw_stall = (result_src_e == RES_MEM) && (rd_e != '0)
                   && ((rd_e == rs1_d) || (rd_e == rs2_d)) && !pcsrc_e;

    assign stall_f = lw_stall;
    assign stall_d = lw_stall;
    assign flush_d = pcsrc_e;
    assign flush_e = lw_stall | pcsrc_e;

endmodule

// File: rtl/ctrl_pipe.sv
// Decode control carried through ID/EX, EX/MEM and MEM/WB, with hazard outputs for the datapath.
module ctrl_pipe
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ALUCTRL_W  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    ctrl_pipe_if.slave  pipe
);
    ctrl_e_t               ctrl_d, ctrl_e;
    logic [ALUCTRL_W-1:0]  alu_control_e;
    logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e;
    ctrl_m_t               ctrl_m;
    logic [REG_ADDR_W-1:0] rd_m;
    ctrl_w_t               ctrl_w;
    logic [REG_ADDR_W-1:0] rd_w;
    logic                  pcsrc_e;
    logic                  flush_e;

    assign ctrl_d = '{reg_write:  pipe.RegWriteD,
                      result_src: pipe.ResultSrcD,
                      mem_write:  pipe.MemWriteD,
                      jump:       pipe.JumpD,
                      branch:     pipe.BranchD,
                      alu_src:    pipe.ALUSrcD};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_e        <= '0;
            alu_control_e <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
        end else if (flush_e) begin
            ctrl_e        <= '0;
            alu_control_e <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
        end else begin
            ctrl_e        <= ctrl_d;
            alu_control_e <= pipe.ALUControlD;
            rs1_e         <= pipe.Rs1D;
            rs2_e         <= pipe.Rs2D;
            rd_e          <= pipe.RdD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_m <= '0;
            rd_m   <= '0;
            ctrl_w <= '0;
            rd_w   <= '0;
        end else begin
            ctrl_m <= '{reg_write:  ctrl_e.reg_write,
                        result_src: ctrl_e.result_src,
                        mem_write:  ctrl_e.mem_write};
            rd_m   <= rd_e;
            ctrl_w <= '{reg_write:  ctrl_m.reg_write,
                        result_src: ctrl_m.result_src};
            rd_w   <= rd_m;
        end
    end

    assign pcsrc_e = (ctrl_e.branch & pipe.ZeroE) | ctrl_e.jump;

    hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .rs1_d        (pipe.Rs1D),
        .rs2_d        (pipe.Rs2D),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .result_src_e (ctrl_e.result_src),
        .pcsrc_e      (pcsrc_e),
        .reg_write_m  (ctrl_m.reg_write),
        .rd_m         (rd_m),
        .reg_write_w  (ctrl_w.reg_write),
        .rd_w         (rd_w),
        .forward_ae   (pipe.ForwardAE),
        .forward_be   (pipe.ForwardBE),
        .stall_f      (pipe.StallF),
        .stall_d      (pipe.StallD),
        .flush_d      (pipe.FlushD),
        .flush_e      (flush_e)
    );

    assign pipe.FlushE      = flush_e;
    assign pipe.PCSrcE      = pcsrc_e;
    assign pipe.ALUControlE = alu_control_e;
    assign pipe.ALUSrcE     = ctrl_e.alu_src;
    assign pipe.MemWriteM   = ctrl_m.mem_write;
    assign pipe.RegWriteM   = ctrl_m.reg_write;
    assign pipe.RdM         = rd_m;
    assign pipe.RegWriteW   = ctrl_w.reg_write;
    assign pipe.ResultSrcW  = ctrl_w.result_src;
    assign pipe.RdW         = rd_w;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed hazard scenarios plus randomized traffic, checked against an instruction-level model.
module tb_ctrl_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    ctrl_pipe_if #(.REG_ADDR_W(5), .ALUCTRL_W(3)) pif ();

    ctrl_pipe #(
        .REG_ADDR_W (5),
        .ALUCTRL_W  (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pipe    (pif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       rw;
        bit [1:0] res;
        bit       mw, j, br, alus;
        bit [2:0] aluc;
        bit [4:0] rs1, rs2, rd;
    } ins_t;

    // Instruction currently occupying each of the E, M and W slots.
    ins_t e_s, m_s, w_s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic ins_t cur_d();
        ins_t d;
        d.rw = pif.RegWriteD; d.res = pif.ResultSrcD; d.mw = pif.MemWriteD;
        d.j = pif.JumpD; d.br = pif.BranchD; d.alus = pif.ALUSrcD;
        d.aluc = pif.ALUControlD; d.rs1 = pif.Rs1D; d.rs2 = pif.Rs2D; d.rd = pif.RdD;
        return d;
    endfunction

    function automatic bit exp_pcsrc();
        return (e_s.br && pif.ZeroE) || e_s.j;
    endfunction

    function automatic bit exp_lw();
        return e_s.res == 2'b01 && e_s.rd != 0
            && (e_s.rd == pif.Rs1D || e_s.rd == pif.Rs2D) && !exp_pcsrc();
    endfunction

    function automatic bit [1:0] exp_fwd(input bit [4:0] rs);
        if (rs != 0 && m_s.rw && m_s.rd == rs) return 2'b10;
        if (rs != 0 && w_s.rw && w_s.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        e_s = '0; m_s = '0; w_s = '0;
    endtask

    task automatic model_step();
        bit squash;
        squash = exp_pcsrc() || exp_lw();
        w_s = m_s;
        m_s = e_s;
        e_s = squash ? '0 : cur_d();
    endtask

    task automatic compare_all();
        check_eq("ALUControlE", 32'(pif.ALUControlE), 32'(e_s.aluc));
        check_eq("ALUSrcE",     32'(pif.ALUSrcE),     32'(e_s.alus));
        check_eq("PCSrcE",      32'(pif.PCSrcE),      32'(exp_pcsrc()));
        check_eq("MemWriteM",   32'(pif.MemWriteM),   32'(m_s.mw));
        check_eq("RegWriteM",   32'(pif.RegWriteM),   32'(m_s.rw));
        check_eq("RdM",         32'(pif.RdM),         32'(m_s.rd));
        check_eq("RegWriteW",   32'(pif.RegWriteW),   32'(w_s.rw));
        check_eq("ResultSrcW",  32'(pif.ResultSrcW),  32'(w_s.res));
        check_eq("RdW",         32'(pif.RdW),         32'(w_s.rd));
        check_eq("ForwardAE",   32'(pif.ForwardAE),   32'(exp_fwd(e_s.rs1)));
        check_eq("ForwardBE",   32'(pif.ForwardBE),   32'(exp_fwd(e_s.rs2)));
        check_eq("StallF",      32'(pif.StallF),      32'(exp_lw()));
        check_eq("StallD",      32'(pif.StallD),      32'(exp_lw()));
        check_eq("FlushD",      32'(pif.FlushD),      32'(exp_pcsrc()));
        check_eq("FlushE",      32'(pif.FlushE),      32'(exp_lw() || exp_pcsrc()));
    endtask

    // Compare the settled cycle, then advance DUT and model together.
    task automatic tick();
        #1;
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_d(input bit rw, input bit [1:0] res, input bit mw, input bit j,
                         input bit br, input bit alus, input bit [2:0] aluc,
                         input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd);
        pif.RegWriteD = rw; pif.ResultSrcD = res; pif.MemWriteD = mw; pif.JumpD = j;
        pif.BranchD = br; pif.ALUSrcD = alus; pif.ALUControlD = aluc;
        pif.Rs1D = rs1; pif.Rs2D = rs2; pif.RdD = rd;
    endtask

    task automatic issue(input bit rw, input bit [1:0] res, input bit mw, input bit j,
                         input bit br, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd);
        set_d(rw, res, mw, j, br, 1'b1, 3'b011, rs1, rs2, rd);
    endtask

    task automatic nop();
        set_d(0, 2'b00, 0, 0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic drain();
        nop();
        pif.ZeroE = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        nop();
        pif.ZeroE = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_RegWriteW", 32'(pif.RegWriteW), 0);
        check_eq("rst_ForwardAE", 32'(pif.ForwardAE), 0);
        compare_all();
        reset_n = 1'b1;

        // Asynchronous reset in the middle of a stream.
        issue(1, 2'b00, 0, 0, 0, 5'd1, 5'd2, 5'd5);
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_RegWriteM", 32'(pif.RegWriteM), 0);
        check_eq("arst_RdM",       32'(pif.RdM), 0);
        check_eq("arst_RegWriteW", 32'(pif.RegWriteW), 0);
        check_eq("arst_RdW",       32'(pif.RdW), 0);
        check_eq("arst_ALUSrcE",   32'(pif.ALUSrcE), 0);
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drain();

        // Back-to-back ALU dependency forwards from MEM.
        issue(1, 2'b00, 0, 0, 0, 5'd1, 5'd2, 5'd5); tick();
        issue(1, 2'b00, 0, 0, 0, 5'd5, 5'd3, 5'd6); tick();
        check_eq("fwd_mem", 32'(pif.ForwardAE), 32'h2);
        drain();

        // One instruction gap forwards from WB.
        issue(1, 2'b00, 0, 0, 0, 5'd1, 5'd2, 5'd5); tick();
        nop(); tick();
        issue(1, 2'b00, 0, 0, 0, 5'd5, 5'd3, 5'd6); tick();
        check_eq("fwd_wb", 32'(pif.ForwardAE), 32'h1);
        drain();

        // Writes to x0 propagate but never forward.
        issue(1, 2'b00, 0, 0, 0, 5'd1, 5'd1, 5'd0); tick();
        issue(1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd4); tick();
        check_eq("x0_RegWriteM", 32'(pif.RegWriteM), 1);
        check_eq("x0_fwd",       32'(pif.ForwardAE), 0);
        drain();

        // Load-use: one bubble, then forward from WB.
        issue(1, 2'b01, 0, 0, 0, 5'd1, 5'd0, 5'd7); tick();
        issue(1, 2'b00, 0, 0, 0, 5'd3, 5'd7, 5'd8);
        #1;
        check_eq("lu_StallF", 32'(pif.StallF), 1);
        check_eq("lu_StallD", 32'(pif.StallD), 1);
        check_eq("lu_FlushE", 32'(pif.FlushE), 1);
        check_eq("lu_FlushD", 32'(pif.FlushD), 0);
        tick();
        check_eq("lu_bubble_StallF", 32'(pif.StallF), 0);
        check_eq("lu_bubble_ALUSrcE", 32'(pif.ALUSrcE), 0);
        check_eq("lu_RdM", 32'(pif.RdM), 7);
        tick();
        check_eq("lu_fwdB", 32'(pif.ForwardBE), 32'h1);
        drain();

        // Taken branch flushes D and E.
        issue(0, 2'b00, 0, 0, 1, 5'd1, 5'd2, 5'd0); tick();
        pif.ZeroE = 1'b1;
        issue(1, 2'b00, 0, 0, 0, 5'd4, 5'd4, 5'd3);
        #1;
        check_eq("br_PCSrcE", 32'(pif.PCSrcE), 1);
        check_eq("br_FlushD", 32'(pif.FlushD), 1);
        check_eq("br_FlushE", 32'(pif.FlushE), 1);
        tick();
        check_eq("br_ALUControlE", 32'(pif.ALUControlE), 0);
        check_eq("br_ALUSrcE",     32'(pif.ALUSrcE), 0);
        drain();

        // Not-taken branch leaves the pipe alone.
        issue(0, 2'b00, 0, 0, 1, 5'd1, 5'd2, 5'd0); tick();
        pif.ZeroE = 1'b0;
        issue(1, 2'b00, 0, 0, 0, 5'd4, 5'd4, 5'd3);
        #1;
        check_eq("nt_PCSrcE", 32'(pif.PCSrcE), 0);
        check_eq("nt_FlushE", 32'(pif.FlushE), 0);
        tick();
        check_eq("nt_ALUControlE", 32'(pif.ALUControlE), 3);
        drain();

        // Jump in E overrides a simultaneous load-use match.
        issue(1, 2'b01, 0, 1, 0, 5'd0, 5'd0, 5'd7); tick();
        issue(1, 2'b00, 0, 0, 0, 5'd7, 5'd1, 5'd2);
        #1;
        check_eq("jl_StallF", 32'(pif.StallF), 0);
        check_eq("jl_StallD", 32'(pif.StallD), 0);
        check_eq("jl_FlushD", 32'(pif.FlushD), 1);
        check_eq("jl_FlushE", 32'(pif.FlushE), 1);
        drain();

        // Latency to M and W.
        issue(0, 2'b00, 1, 0, 0, 5'd1, 5'd2, 5'd0); tick();
        nop(); tick();
        check_eq("lat_MemWriteM", 32'(pif.MemWriteM), 1);
        drain();
        issue(1, 2'b10, 0, 0, 0, 5'd0, 5'd0, 5'd9); tick();
        nop(); tick(); tick();
        check_eq("lat_RegWriteW",  32'(pif.RegWriteW), 1);
        check_eq("lat_RdW",        32'(pif.RdW), 9);
        check_eq("lat_ResultSrcW", 32'(pif.ResultSrcW), 2);
        drain();

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 500; i++) begin
            set_d(1'($urandom_range(1)), 2'($urandom_range(2)), 1'($urandom_range(1)),
                  $urandom_range(7) == 0, $urandom_range(5) == 0, 1'($urandom_range(1)),
                  3'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
                  5'($urandom_range(7)));
            pif.ZeroE = 1'($urandom_range(1));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
